// File: rtl/binary_search_datapath_if.sv
// Bus between the binary search datapath, the user (array load, search
// request, result) and the search controller (start, probe, verdict).
//   clear                                 synchronous flush to EMPTY
//   load_valid/load_data/load_ready       ascending array element stream
//   load_done/sort_error                  array status
//   search_req/search_key/search_ready    search request handshake
//   start/center/found/not_found/eq/gt    controller probe-and-compare path
//   result_valid/found/index/timeout      one-shot search result
// The master modport is the user/controller side; slave is the datapath.
interface binary_search_datapath_if #(
  parameter int ARRAY_SIZE = 10,
  parameter int DATA_WIDTH = 8
);
  localparam int IDX_W = $clog2(ARRAY_SIZE);

  logic                  clear;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_ready;
  logic                  load_done;
  logic                  sort_error;
  logic                  search_req;
  logic [DATA_WIDTH-1:0] search_key;
  logic                  search_ready;
  logic                  start;
  logic [IDX_W-1:0]      center;
  logic                  found;
  logic                  not_found;
  logic                  eq;
  logic                  gt;
  logic                  result_valid;
  logic                  result_found;
  logic [IDX_W-1:0]      result_index;
  logic                  timeout;

  modport master (
    output clear, load_valid, load_data, search_req, search_key,
           center, found, not_found,
    input  load_ready, load_done, sort_error, search_ready, start,
           eq, gt, result_valid, result_found, result_index, timeout
  );

  modport slave (
    input  clear, load_valid, load_data, search_req, search_key,
           center, found, not_found,
    output load_ready, load_done, sort_error, search_ready, start,
           eq, gt, result_valid, result_found, result_index, timeout
  );
endinterface

// File: rtl/binary_search_datapath.sv
// Array-holding responder of the binary search engine.
// Stores a streamed sorted array, latches a search key, pulses start to the
// controller, answers each probed centre index with eq/gt, and turns the
// controller verdict (or a step-count timeout) into one result pulse.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    binary_search_datapath_if.slave (load, search, probe, result)
module binary_search_datapath #(
  parameter int ARRAY_SIZE     = 10,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  binary_search_datapath_if.slave bus
);
  localparam int IDX_W  = $clog2(ARRAY_SIZE);
  localparam int PTR_W  = IDX_W + 1;
  localparam int STEP_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(ARRAY_SIZE - 1);
  localparam logic [PTR_W-1:0]  SIZE_PTR  = PTR_W'(ARRAY_SIZE);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {EMPTY, LOADING, READY, SEARCHING} state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [ARRAY_SIZE];
  logic [DATA_WIDTH-1:0] last_data;
  logic [DATA_WIDTH-1:0] key;
  logic [PTR_W-1:0]      wr_ptr;
  logic [IDX_W-1:0]      hit_index;
  logic [STEP_W-1:0]     step;

  logic                  sort_error_q;
  logic                  start_q;
  logic                  res_valid_q;
  logic                  res_found_q;
  logic [IDX_W-1:0]      res_index_q;
  logic                  timeout_q;

  logic                  load_ready_c;
  logic                  accept;
  logic                  req_acc;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] probe;
  logic                  eq_c;
  logic                  gt_c;
  logic                  term_found;
  logic                  term_miss;
  logic                  term_timeout;

  // Probe compare and next-state decode
  always_comb begin
    state_d      = state_q;
    load_ready_c = (state_q == EMPTY) || (state_q == LOADING);
    accept       = load_ready_c && bus.load_valid;
    req_acc      = (state_q == READY) && bus.search_req;
    in_range     = ({1'b0, bus.center} < SIZE_PTR);
    probe        = in_range ? mem[bus.center] : '0;
    eq_c         = 1'b0;
    gt_c         = 1'b0;
    term_found   = 1'b0;
    term_miss    = 1'b0;
    term_timeout = 1'b0;

    if (state_q == SEARCHING) begin
      // An index past the array end behaves like an element above any key.
      if (!in_range) begin
        gt_c = 1'b1;
      end else begin
        eq_c = (probe == key);
        gt_c = (probe > key);
      end
      term_found   = bus.found;
      term_miss    = !bus.found && bus.not_found;
      term_timeout = !bus.found && !bus.not_found && (step == STEP_LAST);
    end

    unique case (state_q)
      EMPTY: begin
        if (accept) state_d = (wr_ptr == LAST_PTR) ? READY : LOADING;
      end
      LOADING: begin
        if (accept && (wr_ptr == LAST_PTR)) state_d = READY;
      end
      READY: begin
        if (req_acc) state_d = SEARCHING;
      end
      SEARCHING: begin
        if (term_found || term_miss || term_timeout) state_d = READY;
      end
      default: state_d = EMPTY;
    endcase

    if (bus.clear) state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Array storage: contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (accept && !bus.clear) begin
      mem[wr_ptr[IDX_W-1:0]] <= bus.load_data;
      last_data              <= bus.load_data;
    end
  end

  // Control, key capture and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      sort_error_q <= 1'b0;
      key          <= '0;
      hit_index    <= '0;
      step         <= '0;
      start_q      <= 1'b0;
      res_valid_q  <= 1'b0;
      res_found_q  <= 1'b0;
      res_index_q  <= '0;
      timeout_q    <= 1'b0;
    end else begin
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      if (bus.clear) begin
        wr_ptr       <= '0;
        sort_error_q <= 1'b0;
      end else begin
        if (accept) begin
          wr_ptr <= wr_ptr + 1'b1;
          if ((wr_ptr != '0) && (bus.load_data < last_data)) sort_error_q <= 1'b1;
        end
        if (req_acc) begin
          key     <= bus.search_key;
          start_q <= 1'b1;
          step    <= '0;
        end
        if (state_q == SEARCHING) begin
          step <= step + 1'b1;
          if (eq_c) hit_index <= bus.center;
        end
        if (term_found) begin
          res_valid_q <= 1'b1;
          res_found_q <= 1'b1;
          res_index_q <= hit_index;
          timeout_q   <= 1'b0;
        end else if (term_miss || term_timeout) begin
          res_valid_q <= 1'b1;
          res_found_q <= 1'b0;
          res_index_q <= '0;
          timeout_q   <= term_timeout;
        end
      end
    end
  end

  assign bus.load_ready   = load_ready_c;
  assign bus.load_done    = (state_q == READY) || (state_q == SEARCHING);
  assign bus.sort_error   = sort_error_q;
  assign bus.search_ready = (state_q == READY);
  assign bus.start        = start_q;
  assign bus.eq           = eq_c;
  assign bus.gt           = gt_c;
  assign bus.result_valid = res_valid_q;
  assign bus.result_found = res_found_q;
  assign bus.result_index = res_index_q;
  assign bus.timeout      = timeout_q;
endmodule

// File: tb/tb_binary_search_datapath.sv
// Directed bench for binary_search_datapath: loads, probe compares,
// verdict/timeout results, clear and reset recovery.
module tb_binary_search_datapath;
  localparam int AS = 10;
  localparam int DW = 8;
  localparam int TO = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [DW-1:0] good [AS];
  logic [DW-1:0] bad  [AS];

  binary_search_datapath_if #(.ARRAY_SIZE(AS), .DATA_WIDTH(DW)) bus ();

  binary_search_datapath #(
    .ARRAY_SIZE(AS), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_all(input logic [DW-1:0] vals [AS]);
    for (int i = 0; i < AS; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = vals[i];
      tick();
    end
    bus.load_valid = 1'b0;
  endtask

  task automatic request(input logic [DW-1:0] k);
    check_val("req_ready", bus.search_ready, 1);
    bus.search_req = 1'b1;
    bus.search_key = k;
    tick();
    bus.search_req = 1'b0;
    check_val("start_pulse", bus.start, 1);
    check_val("ready_low_in_search", bus.search_ready, 0);
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  initial begin
    int cnt;
    int starts;
    n_checks = 0;
    n_fail   = 0;
    good = '{8'd2, 8'd5, 8'd9, 8'd14, 8'd20, 8'd27, 8'd33, 8'd41, 8'd50, 8'd62};
    bad  = '{8'd2, 8'd5, 8'd9, 8'd14, 8'd3, 8'd27, 8'd33, 8'd41, 8'd50, 8'd62};

    rst_n          = 1'b0;
    bus.clear      = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.search_req = 1'b0;
    bus.search_key = '0;
    bus.center     = '0;
    bus.found      = 1'b0;
    bus.not_found  = 1'b0;
    tick();
    tick();

    // reset state
    check_val("rst_load_ready", bus.load_ready, 1);
    check_val("rst_load_done", bus.load_done, 0);
    check_val("rst_sort_error", bus.sort_error, 0);
    check_val("rst_search_ready", bus.search_ready, 0);
    check_val("rst_start", bus.start, 0);
    check_val("rst_result_valid", bus.result_valid, 0);
    check_val("rst_result_found", bus.result_found, 0);
    check_val("rst_result_index", bus.result_index, 0);
    check_val("rst_timeout", bus.timeout, 0);
    check_val("rst_eq", bus.eq, 0);
    check_val("rst_gt", bus.gt, 0);
    rst_n = 1'b1;
    tick();

    // sorted load
    bus.load_valid = 1'b1;
    bus.load_data  = good[0];
    tick();
    check_val("load1_ready", bus.load_ready, 1);
    check_val("load1_done", bus.load_done, 0);
    for (int i = 1; i < AS; i++) begin
      bus.load_data = good[i];
      tick();
    end
    bus.load_valid = 1'b0;
    check_val("load_done", bus.load_done, 1);
    check_val("load_ready_off", bus.load_ready, 0);
    check_val("load_sort_ok", bus.sort_error, 0);
    check_val("load_search_ready", bus.search_ready, 1);

    // hit on key 27 at index 5, plus compare corner cases
    request(8'd27);
    bus.center = 4'd5;
    #1;
    check_val("k27_c5_eq", bus.eq, 1);
    check_val("k27_c5_gt", bus.gt, 0);
    tick();
    check_val("start_one_cycle", bus.start, 0);
    bus.center = 4'd8;
    #1;
    check_val("k27_c8_eq", bus.eq, 0);
    check_val("k27_c8_gt", bus.gt, 1);
    bus.center = 4'd2;
    #1;
    check_val("k27_c2_eq", bus.eq, 0);
    check_val("k27_c2_gt", bus.gt, 0);
    bus.center = 4'd10;
    #1;
    check_val("k27_c10_eq", bus.eq, 0);
    check_val("k27_c10_gt", bus.gt, 1);
    bus.found = 1'b1;
    tick();
    bus.found = 1'b0;
    check_val("hit_valid", bus.result_valid, 1);
    check_val("hit_found", bus.result_found, 1);
    check_val("hit_index", bus.result_index, 5);
    check_val("hit_timeout", bus.timeout, 0);
    check_val("hit_ready_back", bus.search_ready, 1);
    check_val("idle_eq", bus.eq, 0);
    check_val("idle_gt", bus.gt, 0);
    tick();
    check_val("hit_valid_1cyc", bus.result_valid, 0);
    check_val("hit_found_hold", bus.result_found, 1);
    check_val("hit_index_hold", bus.result_index, 5);

    // miss on key 4
    request(8'd4);
    bus.center    = 4'd4;
    bus.not_found = 1'b1;
    tick();
    bus.not_found = 1'b0;
    check_val("miss_valid", bus.result_valid, 1);
    check_val("miss_found", bus.result_found, 0);
    check_val("miss_index", bus.result_index, 0);
    check_val("miss_timeout", bus.timeout, 0);

    // back-to-back request; found beats not_found
    request(8'd50);
    bus.center = 4'd8;
    #1;
    check_val("k50_c8_eq", bus.eq, 1);
    tick();
    bus.found     = 1'b1;
    bus.not_found = 1'b1;
    tick();
    bus.found     = 1'b0;
    bus.not_found = 1'b0;
    check_val("both_valid", bus.result_valid, 1);
    check_val("both_found", bus.result_found, 1);
    check_val("both_index", bus.result_index, 8);
    tick();

    // silent controller -> timeout
    bus.center = 4'd0;
    request(8'd7);
    cnt    = 0;
    starts = 0;
    bus.search_req = 1'b1;
    while (cnt < 40) begin
      tick();
      cnt++;
      if (cnt == 3) bus.search_req = 1'b0;
      if (bus.start) starts++;
      if (bus.result_valid) break;
    end
    bus.search_req = 1'b0;
    check_val("to_latency", cnt, TO);
    check_val("to_no_restart", starts, 0);
    check_val("to_valid", bus.result_valid, 1);
    check_val("to_flag", bus.timeout, 1);
    check_val("to_found", bus.result_found, 0);
    check_val("to_index", bus.result_index, 0);
    tick();

    // clear mid-search with a verdict pending
    request(8'd14);
    bus.center = 4'd3;
    tick();
    bus.clear = 1'b1;
    bus.found = 1'b1;
    tick();
    bus.clear = 1'b0;
    bus.found = 1'b0;
    check_val("clr_no_result", bus.result_valid, 0);
    check_val("clr_load_ready", bus.load_ready, 1);
    check_val("clr_load_done", bus.load_done, 0);
    check_val("clr_search_ready", bus.search_ready, 0);
    tick();
    check_val("clr_no_result2", bus.result_valid, 0);

    // unsorted load
    for (int i = 0; i < AS; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = bad[i];
      tick();
      if (i == 3) check_val("sort_before", bus.sort_error, 0);
      if (i == 4) check_val("sort_flag", bus.sort_error, 1);
    end
    bus.load_valid = 1'b0;
    check_val("sort_sticky", bus.sort_error, 1);
    check_val("sort_load_done", bus.load_done, 1);
    pulse_clear();
    check_val("sort_cleared", bus.sort_error, 0);
    check_val("sort_clr_done", bus.load_done, 0);
    load_all(good);
    check_val("reload_done", bus.load_done, 1);
    check_val("reload_sort", bus.sort_error, 0);

    // reset mid-load
    pulse_clear();
    for (int i = 0; i < 5; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = good[i];
      tick();
    end
    bus.load_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("rstm_load_ready", bus.load_ready, 1);
    check_val("rstm_load_done", bus.load_done, 0);
    check_val("rstm_result", bus.result_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    load_all(good);
    check_val("fresh_done", bus.load_done, 1);

    // final hit at the top entry after a fresh load
    request(8'd62);
    bus.center = 4'd0;
    #1;
    check_val("k62_c0_eq", bus.eq, 0);
    check_val("k62_c0_gt", bus.gt, 0);
    bus.center = 4'd9;
    #1;
    check_val("k62_c9_eq", bus.eq, 1);
    tick();
    bus.found = 1'b1;
    tick();
    bus.found = 1'b0;
    check_val("fresh_found", bus.result_found, 1);
    check_val("fresh_index", bus.result_index, 9);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
